// File: rtl/serial_add_ctrl_if.sv
// Handshake/result bundle for serial_add_ctrl: the requester drives start/a/b,
// the adder returns busy/done and the registered sum, cout and ovf flags.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder (LSB first, one bit per clock) with an IDLE/RUN/DONE controller.
// Optional macro SERIAL_ADD_OVF_EN enables the two's-complement overflow flag.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_add_ctrl_if.slave    bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;

    // Shared full-adder cell built from two half adders.
    logic w_hs1, w_hc1, w_s, w_hc2, w_c, w_last;
    logic [WIDTH-1:0] w_res_next;

    assign w_hs1      = r_a[0] ^ r_b[0];
    assign w_hc1      = r_a[0] & r_b[0];
    assign w_s        = w_hs1 ^ r_carry;
    assign w_hc2      = w_hs1 & r_carry;
    assign w_c        = w_hc1 | w_hc2;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_res_next = {w_s, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_res   <= w_res_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_c;
                    r_cnt   <= r_cnt + 1'b1;
                    // Last bit: publish the completed word as DONE is entered.
                    if (w_last) begin
                        r_sum   <= w_res_next;
                        r_cout  <= w_c;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // During the last RUN cycle r_carry is the carry into the MSB.
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (r_state == S_RUN && w_last) begin
            r_ovf <= r_carry ^ w_c;
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.busy = (r_state == S_RUN) || (r_state == S_DONE);
    assign bus.done = (r_state == S_DONE);
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8 and WIDTH=16 against an
// arithmetic reference model; honours SERIAL_ADD_OVF_EN when computing ovf.
module tb_serial_add_ctrl;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    serial_add_ctrl_if #(.WIDTH(8))  if8 ();
    serial_add_ctrl_if #(.WIDTH(16)) if16 ();

    serial_add_ctrl #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
    serial_add_ctrl #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_in(input int w, input logic s, input logic [31:0] a, input logic [31:0] b);
        if (w == 8) begin
            if8.start = s;
            if8.a     = a[7:0];
            if8.b     = b[7:0];
        end else begin
            if16.start = s;
            if16.a     = a[15:0];
            if16.b     = b[15:0];
        end
    endtask

    function automatic logic get_done(input int w);
        return (w == 8) ? if8.done : if16.done;
    endfunction

    function automatic logic get_busy(input int w);
        return (w == 8) ? if8.busy : if16.busy;
    endfunction

    function automatic logic [31:0] get_sum(input int w);
        return (w == 8) ? {24'd0, if8.sum} : {16'd0, if16.sum};
    endfunction

    function automatic logic get_cout(input int w);
        return (w == 8) ? if8.cout : if16.cout;
    endfunction

    function automatic logic get_ovf(input int w);
        return (w == 8) ? if8.ovf : if16.ovf;
    endfunction

    // Reference: plain integer addition, then modulo/carry/sign rules.
    task automatic check_res(input int w, input logic [31:0] a, input logic [31:0] b, input string tag);
        longint unsigned mask, am, bm, t, e_sum, e_cout, e_ovf;
        mask   = (64'd1 << w) - 1;
        am     = a & mask;
        bm     = b & mask;
        t      = am + bm;
        e_sum  = t & mask;
        e_cout = (t >> w) & 1;
`ifdef SERIAL_ADD_OVF_EN
        e_ovf  = (((am >> (w-1)) & 1) == ((bm >> (w-1)) & 1) &&
                  ((e_sum >> (w-1)) & 1) != ((am >> (w-1)) & 1)) ? 1 : 0;
`else
        e_ovf  = 0;
`endif
        chk({tag, "_sum"},  get_sum(w),  e_sum);
        chk({tag, "_cout"}, get_cout(w), e_cout);
        chk({tag, "_ovf"},  get_ovf(w),  e_ovf);
    endtask

    // Issue one request from IDLE; returns at the negedge where done is seen.
    // lat counts cycles inclusively from the start cycle to the done cycle.
    task automatic do_op(input int w, input logic [31:0] a, input logic [31:0] b, output int lat);
        int cnt;
        cnt = 0;
        set_in(w, 1'b1, a, b);
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) set_in(w, 1'b0, $urandom, $urandom);
        end while (!get_done(w) && cnt < 200);
        if (!get_done(w)) chk("done_timeout", get_done(w), 1'b1);
        lat = cnt + 1;
    endtask

    initial begin
        int          lat, cnt, done_cnt, first_lat;
        logic [31:0] ra, rb, ea, eb;
        logic [31:0] sum_at_done;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        set_in(8, 1'b0, 0, 0);
        set_in(16, 1'b0, 0, 0);
        repeat (3) @(negedge clk);

        for (int w = 8; w <= 16; w += 8) begin
            chk("rst_busy", get_busy(w), 1'b0);
            chk("rst_done", get_done(w), 1'b0);
            chk("rst_sum",  get_sum(w),  32'd0);
            chk("rst_cout", get_cout(w), 1'b0);
            chk("rst_ovf",  get_ovf(w),  1'b0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Directed vectors at WIDTH=8
        do_op(8, 32'h05, 32'h03, lat);
        chk("lat_05_03", lat, 10);
        check_res(8, 32'h05, 32'h03, "d05_03");
        chk("sum_05_03_exact", get_sum(8), 32'h08);
        @(negedge clk);
        do_op(8, 32'hFF, 32'h01, lat);
        check_res(8, 32'hFF, 32'h01, "dFF_01");
        chk("cout_FF_01", get_cout(8), 1'b1);
        @(negedge clk);
        do_op(8, 32'h7F, 32'h01, lat);
        check_res(8, 32'h7F, 32'h01, "d7F_01");
        chk("sum_7F_01_exact", get_sum(8), 32'h80);
        @(negedge clk);

        // Second start while busy must be ignored
        set_in(8, 1'b1, 32'h10, 32'h10);
        cnt = 0; done_cnt = 0; first_lat = 0; sum_at_done = 0;
        repeat (20) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) set_in(8, 1'b0, 0, 0);
            if (cnt == 3) set_in(8, 1'b1, 32'hAA, 32'h55);
            if (cnt == 4) set_in(8, 1'b0, 0, 0);
            if (if8.done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    first_lat   = cnt + 1;
                    sum_at_done = get_sum(8);
                end
            end
        end
        chk("ignore_done_count", done_cnt, 1);
        chk("ignore_lat", first_lat, 10);
        chk("ignore_sum", sum_at_done, 32'h20);
        chk("hold_sum", get_sum(8), 32'h20);
        chk("ignore_idle_busy", get_busy(8), 1'b0);

        // Reset four cycles into RUN aborts the operation
        set_in(8, 1'b1, 32'h33, 32'h44);
        @(negedge clk);
        set_in(8, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", get_busy(8), 1'b0);
        chk("midrst_sum",  get_sum(8),  32'd0);
        chk("midrst_done", get_done(8), 1'b0);
        rst = 1'b0;
        done_cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (if8.done) done_cnt++;
        end
        chk("midrst_no_done", done_cnt, 0);
        do_op(8, 32'h01, 32'h02, lat);
        check_res(8, 32'h01, 32'h02, "after_rst");
        chk("after_rst_lat", lat, 10);
        @(negedge clk);

        // start held high: back-to-back ops, operands only matter at accept
        ea = $urandom; eb = $urandom;
        set_in(8, 1'b1, ea, eb);
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
                set_in(8, 1'b1, $urandom, $urandom);
            end while (!if8.done && cnt < 200);
            if (!if8.done) chk("b2b_timeout", if8.done, 1'b1);
            chk("b2b_lat", cnt + 1, 10);
            check_res(8, ea, eb, "b2b");
            @(negedge clk);
            chk("b2b_idle_busy", get_busy(8), 1'b0);
            chk("b2b_idle_done", get_done(8), 1'b0);
            ea = $urandom; eb = $urandom;
            set_in(8, (k < 3), ea, eb);
        end
        @(negedge clk);

        // Random sweep at both widths
        for (int w = 8; w <= 16; w += 8) begin
            for (int i = 0; i < 1000; i++) begin
                ra = $urandom;
                rb = $urandom;
                do_op(w, ra, rb, lat);
                chk("rand_lat", lat, w + 2);
                check_res(w, ra, rb, "rand");
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
